// File: rtl/gpr_mp_sb.sv
// ---------------------------------------------------------------------------
// gpr_mp_sb : multi-port general purpose register file with an integrated
//             scoreboard of pending writes.
//
// x0 is hard-wired to zero. Every write port is bypassed to every read port
// in the same cycle. When several write ports target the same register, the
// lowest-index port wins. Each register r != 0 has a busy bit:
//   - The issue stage sets it when it allocates the register as a destination.
//   - The writeback stage clears it with a write that has its wclr flag set.
// A flush clears every busy bit and leaves the register contents unchanged.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset (registers, busy bits, count)
//   we_i        per write port enable
//   waddr_i     write addresses, port k at [k*AW +: AW]
//   wdata_i     write data, port k at [k*DW +: DW]
//   wclr_i      per write port: the write also clears the destination busy bit
//   raddr_i     read addresses, port p at [p*AW +: AW]
//   rdata_o     read data, combinational, includes write bypass
//   rbusy_o     busy flag per read port, combinational
//   is_valid_i  per issue port allocate valid
//   is_rd_i     destination register per issue port
//   flush_i     clear all busy bits
//   busy_cnt_o  registered population count of the busy vector
// ---------------------------------------------------------------------------
module gpr_mp_sb #(
  parameter int REG_NUM = 32,
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int NR_RD   = 4,
  parameter int NR_WR   = 2,
  parameter int NR_IS   = 2,
  parameter int CW      = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NR_WR-1:0]    we_i,
  input  logic [NR_WR*AW-1:0] waddr_i,
  input  logic [NR_WR*DW-1:0] wdata_i,
  input  logic [NR_WR-1:0]    wclr_i,
  input  logic [NR_RD*AW-1:0] raddr_i,
  output logic [NR_RD*DW-1:0] rdata_o,
  output logic [NR_RD-1:0]    rbusy_o,
  input  logic [NR_IS-1:0]    is_valid_i,
  input  logic [NR_IS*AW-1:0] is_rd_i,
  input  logic                flush_i,
  output logic [CW-1:0]       busy_cnt_o
);

  // Number of set bits in the busy vector.
  function automatic logic [CW-1:0] popcount(input logic [REG_NUM-1:0] vec);
    logic [CW-1:0] acc;
    acc = {CW{1'b0}};
    for (int i = 0; i < REG_NUM; i++) begin
      acc = acc + CW'(vec[i]);
    end
    return acc;
  endfunction

  logic [DW-1:0]      regs_r [REG_NUM];
  logic [REG_NUM-1:0] busy_r;
  logic [CW-1:0]      busy_cnt_r;

  logic [REG_NUM-1:0] wr_hit_s [NR_WR];   // port k write enabled and aimed at r
  logic [REG_NUM-1:0] is_hit_s [NR_IS];   // issue port j allocates r
  logic [REG_NUM-1:0] wr_en_s;
  logic [DW-1:0]      wr_data_s [REG_NUM];
  logic [REG_NUM-1:0] set_s;
  logic [REG_NUM-1:0] clr_s;
  logic [REG_NUM-1:0] busy_nxt_s;

  // Address match of every write and issue port against every register.
  always_comb begin
    for (int k = 0; k < NR_WR; k++) begin
      for (int r = 0; r < REG_NUM; r++) begin
        wr_hit_s[k][r] = we_i[k] && (waddr_i[k*AW +: AW] == AW'(r));
      end
    end
    for (int j = 0; j < NR_IS; j++) begin
      for (int r = 0; r < REG_NUM; r++) begin
        is_hit_s[j][r] = is_valid_i[j] && (is_rd_i[j*AW +: AW] == AW'(r));
      end
    end
  end

  // Per-register write enable, winning data, busy set and busy clear.
  // Ports are scanned from highest to lowest index so the lowest port overrides.
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      wr_en_s[r]   = 1'b0;
      wr_data_s[r] = {DW{1'b0}};
      clr_s[r]     = 1'b0;
      set_s[r]     = 1'b0;
      for (int k = NR_WR - 1; k >= 0; k--) begin
        wr_en_s[r]   = wr_en_s[r] | wr_hit_s[k][r];
        wr_data_s[r] = wr_hit_s[k][r] ? wdata_i[k*DW +: DW] : wr_data_s[r];
        clr_s[r]     = clr_s[r] | (wr_hit_s[k][r] & wclr_i[k]);
      end
      for (int j = 0; j < NR_IS; j++) begin
        set_s[r] = set_s[r] | is_hit_s[j][r];
      end
    end
  end

  // Scoreboard next state: flush beats issue, and issue beats a writeback clear.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int r = 0; r < REG_NUM; r++) begin
      if (flush_i) begin
        busy_nxt_s[r] = 1'b0;
      end else if (set_s[r]) begin
        busy_nxt_s[r] = 1'b1;
      end else if (clr_s[r]) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Register array storage; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        regs_r[r] <= {DW{1'b0}};
      end
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        if (wr_en_s[r] && (r != 0)) begin
          regs_r[r] <= wr_data_s[r];
        end
      end
    end
  end

  // Busy vector and its count. The count is taken from the next-state vector,
  // so it lines up with the busy bits after the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r     <= {REG_NUM{1'b0}};
      busy_cnt_r <= {CW{1'b0}};
    end else begin
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= popcount(busy_nxt_s);
    end
  end

  assign busy_cnt_o = busy_cnt_r;

  // Read ports: x0 and out-of-range addresses read 0. Otherwise the read
  // returns the lowest-index matching write, or the stored value. Busy is
  // hidden when a clearing write to the same register supplies the data now.
  always_comb begin
    for (int p = 0; p < NR_RD; p++) begin
      rdata_o[p*DW +: DW] = {DW{1'b0}};
      rbusy_o[p]          = 1'b0;
      if ((raddr_i[p*AW +: AW] == {AW{1'b0}}) ||
          ({1'b0, raddr_i[p*AW +: AW]} >= (AW+1)'(REG_NUM))) begin
        rdata_o[p*DW +: DW] = {DW{1'b0}};
        rbusy_o[p]          = 1'b0;
      end else begin
        rdata_o[p*DW +: DW] = regs_r[raddr_i[p*AW +: AW]];
        for (int k = NR_WR - 1; k >= 0; k--) begin
          rdata_o[p*DW +: DW] = (we_i[k] && (waddr_i[k*AW +: AW] == raddr_i[p*AW +: AW]))
                                ? wdata_i[k*DW +: DW] : rdata_o[p*DW +: DW];
        end
        rbusy_o[p] = busy_r[raddr_i[p*AW +: AW]] & ~clr_s[raddr_i[p*AW +: AW]];
      end
    end
  end

endmodule

// File: doc/gpr_mp_sb.md
Name: gpr_mp_sb

Overview:
- Parametrised successor to the core's fixed 4-read/2-write GPR: configurable read/write port counts, full cross-port write bypass, and an integrated per-register scoreboard of pending writes.
- Sits between the issue/ICU stage (read operands, allocate destinations) and WBU (commit results).
- Issue logic uses the busy flags for RAW stalls; WBU clears them on writeback.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hard-wired zero.
- AW, 5, register address width; REG_NUM <= 2**AW.
- DW, 32, register data width.
- NR_RD, 4, number of read ports.
- NR_WR, 2, number of write ports; port 0 has highest priority.
- NR_IS, 2, number of issue (destination-allocate) ports.
- CW, 6, width of busy_cnt_o; must satisfy 2**CW > REG_NUM.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we_i  in  NR_WR  per-port write enable.
- waddr_i  in  NR_WR*AW  write addresses, port k at [k*AW +: AW].
- wdata_i  in  NR_WR*DW  write data, port k at [k*DW +: DW].
- wclr_i  in  NR_WR  per-port flag: this write also clears the destination's busy bit.
- raddr_i  in  NR_RD*AW  read addresses.
- rdata_o  out  NR_RD*DW  read data; combinational, with bypass.
- rbusy_o  out  NR_RD  busy flag of each read address; combinational.
- is_valid_i  in  NR_IS  issue-allocate valid.
- is_rd_i  in  NR_IS*AW  destination register of each issued instruction.
- flush_i  in  1  clears all busy bits; register contents are untouched.
- busy_cnt_o  out  CW  registered count of busy registers.

Behaviour:
- Reset (rst=1 at posedge): all registers, all busy bits and busy_cnt_o become 0. Reset dominates every other input that cycle. rdata_o still returns bypassed wdata during reset; rbusy_o reads 0 after the reset edge.
- Write:
  - Register r updates at posedge if any we_i[k] is set with waddr==r, r != 0.
  - On a multi-port write to the same address, the lowest-index port wins.
  - Writes to x0 are discarded.
- Read (combinational, same cycle):
  - raddr==0 returns 0.
  - Else, if any we_i[k] with waddr==raddr, returns wdata of the lowest such k. This bypass covers every write port, not only a paired port.
  - Else returns the stored value.
  - Addresses >= REG_NUM return 0 and rbusy=0.
- Scoreboard, next-state per register r != 0, in priority order:
  1. rst -> 0.
  2. flush_i -> 0, overriding issue in the same cycle.
  3. any is_valid_i[j] with is_rd==r -> 1 (set wins over a same-cycle clear).
  4. any we_i[k] & wclr_i[k] with waddr==r -> 0.
  5. else hold.
- busy[0] is always 0. Duplicate issues to the same rd in one cycle set the bit once (no counting).
- rbusy_o:
  - Equals busy[raddr], masked to 0 if that register is being cleared this cycle by a we&wclr port, since the bypass already supplies the data.
  - Same-cycle issue is not reflected; it becomes visible next cycle.
- busy_cnt_o: popcount of the busy vector, registered. Its latency equals the busy bits (value after edge N reflects state after edge N).
- No handshake back-pressure; every input is accepted each cycle.

Test Plan:
- Reset, then read all 4 ports at x5, x0, x31, x1 -> rdata all 0, rbusy all 0, busy_cnt_o=0.
- Same cycle: we=2'b11, waddr0=waddr1=7, wdata0=0xAAAA_0001, wdata1=0x5555_0002 -> port 0 wins. Same-cycle read of x7 returns 0xAAAA_0001; next cycle stored x7=0xAAAA_0001.
- Write x9=0x1234 on port 1 only, read x9 on all 4 read ports in the same cycle -> all return 0x1234 (cross-port bypass); write to x0=0xFFFF -> x0 still reads 0.
- Issue rd=3 and rd=4 -> next cycle rbusy(x3)=rbusy(x4)=1, busy_cnt_o=2. Then write x3 with wclr=1, data 0x77 -> same-cycle rbusy(x3)=0, rdata=0x77; next cycle busy_cnt_o=1.
- Same cycle: issue rd=10 and write x10 with wclr=1 -> busy[10]=1 after the edge (set wins). Next: flush_i=1 together with issue rd=11 -> busy_cnt_o=0, x10 contents preserved.
- Registers x1..x31 hold nonzero data with 5 busy bits set; assert rst=1 while we_i=2'b01 writes x2 -> all registers 0, busy_cnt_o=0 after the edge, write discarded.
